instr_fetch_unit: RTL

- Consumer side of the program counter: reads the architectural `pc` while the core controller is in its FETCH state and issues one instruction-memory read per FETCH visit.
- Returns the fetched word to the decoder, with a one-cycle completion pulse that lets the controller advance.
- Detects misaligned PCs, bus errors and unresponsive memory, and reports them as fetch faults.

---
 rtl/core_pkg.sv | 30 +++
 rtl/fetch_timeout_ctr.sv | 34 +++
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: controller state codes, fetch FSM encoding, fault causes.
package core_pkg;

  typedef enum logic [3:0] {
    CtrlReset   = 4'd0,
    CtrlFetch   = 4'd1,
    CtrlDecode  = 4'd2,
    CtrlExecute = 4'd4,
    CtrlMem     = 4'd5,
    CtrlWb      = 4'd6
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FetchIdle = 2'd0,
    FetchReq  = 2'd1,
    FetchResp = 2'd2,
    FetchDone = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    FaultNone       = 2'd0,
    FaultMisaligned = 2'd1,
    FaultBusErr     = 2'd2,
    FaultTimeout    = 2'd3
  } fault_cause_e;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating 8-bit cycle counter that flags when an outstanding memory access has run too long.
module fetch_timeout_ctr #(
  parameter logic [7:0] Timeout = 8'd255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Look-ahead so the owner can leave on the same edge that brings the count to Timeout.
  assign expired_o = en_i && (({1'b0, cnt_q} + 9'd1) >= {1'b0, Timeout});

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one memory read per controller FETCH visit, with fault detection.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter logic [3:0] FetchState = 4'd1,
  parameter logic [7:0] Timeout    = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  state_i,
  input  logic [31:0] pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        fetch_done_o,
  output logic        fetch_fault_o,
  output logic [1:0]  fault_cause_o,
  output logic        busy_o
);

  fetch_state_e fsm_q, fsm_d;
  fault_cause_e cause_q, cause_d;
  logic         armed_q, armed_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         ctr_clear, ctr_en, expired;

  assign ctr_en = (fsm_q == FetchReq) || (fsm_q == FetchResp);

  fetch_timeout_ctr #(
    .Timeout (Timeout)
  ) u_timeout_ctr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (ctr_clear),
    .en_i      (ctr_en),
    .expired_o (expired)
  );

  always_comb begin
    fsm_d     = fsm_q;
    cause_d   = cause_q;
    armed_d   = armed_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    ctr_clear = 1'b0;

    if (state_i != FetchState) begin
      armed_d = 1'b1;
    end

    unique case (fsm_q)
      FetchIdle: begin
        if ((state_i == FetchState) && armed_q) begin
          if (pc_i[1:0] != 2'b00) begin
            fsm_d   = FetchDone;
            cause_d = FaultMisaligned;
            instr_d = NopInstr;
            valid_d = 1'b0;
          end else begin
            fsm_d     = FetchReq;
            addr_d    = pc_i;
            valid_d   = 1'b0;
            ctr_clear = 1'b1;
          end
        end
      end
      FetchReq: begin
        if (expired) begin
          fsm_d   = FetchDone;
          cause_d = FaultTimeout;
          instr_d = NopInstr;
        end else if (mem_gnt_i) begin
          fsm_d = FetchResp;
        end
      end
      FetchResp: begin
        // A response landing in the expiry cycle still completes the fetch.
        if (mem_rvalid_i) begin
          fsm_d = FetchDone;
          if (mem_err_i) begin
            cause_d = FaultBusErr;
            instr_d = NopInstr;
            valid_d = 1'b0;
          end else begin
            cause_d = FaultNone;
            instr_d = mem_rdata_i;
            valid_d = 1'b1;
          end
        end else if (expired) begin
          fsm_d   = FetchDone;
          cause_d = FaultTimeout;
          instr_d = NopInstr;
        end
      end
      FetchDone: begin
        fsm_d = FetchIdle;
      end
      default: begin
        fsm_d = FetchIdle;
      end
    endcase

    if ((fsm_d == FetchDone) && (fsm_q != FetchDone)) begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= FetchIdle;
      cause_q <= FaultNone;
      armed_q <= 1'b1;
      addr_q  <= '0;
      instr_q <= NopInstr;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cause_q <= cause_d;
      armed_q <= armed_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign mem_req_o     = (fsm_q == FetchReq);
  assign mem_addr_o    = addr_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign fetch_done_o  = (fsm_q == FetchDone);
  assign fetch_fault_o = (fsm_q == FetchDone) && (cause_q != FaultNone);
  assign fault_cause_o = cause_q;
  assign busy_o        = (fsm_q != FetchIdle);

endmodule
